// File: rtl/grid_mover_if.sv
// grid_mover_if
// Bundles the control inputs and position outputs of grid_mover so that the
// input decoder / scene logic (master) and the mover (slave) share one port.
//   scene      : 00 start, 01 play, 10 win, 11 lose
//   map        : [0:MAP_W*MAP_H-1], bit x+y*MAP_W set means wall
//   dir_req    : 00 up, 01 down, 10 left, 11 right
//   dir_valid  : one-cycle strobe latching dir_req as the pending turn
//   pos_x/pos_y: current tile
//   cur_dir    : current direction of travel
//   step_pulse : one-cycle, position changed
//   blocked    : one-cycle, a step tick found no legal move
interface grid_mover_if #(
   parameter int MAP_W = 18,
   parameter int MAP_H = 5,
   parameter int POS_W = 5
);
   logic [1:0]             scene;
   logic [0:MAP_W*MAP_H-1] map;
   logic [1:0]             dir_req;
   logic                   dir_valid;
   logic [POS_W-1:0]       pos_x;
   logic [POS_W-1:0]       pos_y;
   logic [1:0]             cur_dir;
   logic                   step_pulse;
   logic                   blocked;

   modport master (
      output scene, map, dir_req, dir_valid,
      input  pos_x, pos_y, cur_dir, step_pulse, blocked
   );

   modport slave (
      input  scene, map, dir_req, dir_valid,
      output pos_x, pos_y, cur_dir, step_pulse, blocked
   );
endinterface

// File: rtl/grid_mover.sv
// grid_mover
// Tile-grid mover for a player or ghost sprite. Holds a tile position on a
// MAP_W x MAP_H wall map and steps at most one tile per step tick, with one
// buffered turn request that is applied at the first tick where it is legal.
// Optional horizontal tunnel wrap.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : grid_mover_if slave (scene, map, dir_req, dir_valid in;
//           pos_x, pos_y, cur_dir, step_pulse, blocked out)
module grid_mover #(
   parameter int         MAP_W       = 18,
   parameter int         MAP_H       = 5,
   parameter int         POS_W       = 5,
   parameter int         START_X     = 9,
   parameter int         START_Y     = 4,
   parameter logic [1:0] START_DIR   = 2'b10,
   parameter int         STEP_PERIOD = 33554432,
   parameter bit         WRAP_X      = 1'b0
) (
   input logic         clk,
   input logic         rst_n,
   grid_mover_if.slave bus
);

   localparam int N     = MAP_W * MAP_H;
   localparam int AW    = $clog2(N);
   localparam int IDX_W = $clog2(N) + 1;
   localparam int CNT_W = $clog2(STEP_PERIOD);
   localparam logic [POS_W-1:0] LAST_X = POS_W'(MAP_W - 1);
   localparam logic [POS_W-1:0] LAST_Y = POS_W'(MAP_H - 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [POS_W-1:0] pos_x_r;
   logic [POS_W-1:0] pos_y_r;
   logic [1:0]       dir_r;
   logic             pend_valid;
   logic [1:0]       pend_dir;
   logic             step_r;
   logic             blocked_r;
   logic             tick;
   logic [2*POS_W:0] pend_try;
   logic [2*POS_W:0] cur_try;

   // Evaluates one direction from (x,y): returns {legal, target_x, target_y}.
   // The cell index is formed at a width that holds MAP_W*MAP_H without
   // truncating y*MAP_W; an index past the map is treated as a wall.
   function automatic logic [2*POS_W:0] try_move(
      input logic [1:0]       d,
      input logic [POS_W-1:0] x,
      input logic [POS_W-1:0] y,
      input logic [0:N-1]     m
   );
      logic [POS_W-1:0] tx;
      logic [POS_W-1:0] ty;
      logic             in_range;
      logic [IDX_W-1:0] idx;
      logic             wall;
      tx       = x;
      ty       = y;
      in_range = 1'b0;
      case (d)
         2'b00: if (y != '0) begin
            ty       = y - POS_W'(1);
            in_range = 1'b1;
         end
         2'b01: if (y < LAST_Y) begin
            ty       = y + POS_W'(1);
            in_range = 1'b1;
         end
         2'b10: if (x != '0) begin
            tx       = x - POS_W'(1);
            in_range = 1'b1;
         end else if (WRAP_X) begin
            tx       = LAST_X;
            in_range = 1'b1;
         end
         default: if (x < LAST_X) begin
            tx       = x + POS_W'(1);
            in_range = 1'b1;
         end else if (WRAP_X) begin
            tx       = '0;
            in_range = 1'b1;
         end
      endcase
      idx  = IDX_W'(tx) + IDX_W'(ty) * IDX_W'(MAP_W);
      wall = (idx < IDX_W'(N)) ? m[idx[AW-1:0]] : 1'b1;
      return {in_range & ~wall, tx, ty};
   endfunction

   // Both candidate moves are evaluated against the live map; they only
   // matter on the tick cycle, which is how map edits get sampled per tick.
   assign pend_try = try_move(pend_dir, pos_x_r, pos_y_r, bus.map);
   assign cur_try  = try_move(dir_r, pos_x_r, pos_y_r, bus.map);
   assign tick     = (state == RUN) && (cnt == CNT_W'(STEP_PERIOD - 1));

   // Scene FSM, step counter, pending-turn buffer and move decision. The
   // current state decides this cycle's action; the scene input only picks
   // the state for the next cycle. A turn request arriving on a tick cycle
   // overwrites the buffer after the tick has already used the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         pos_x_r    <= POS_W'(START_X);
         pos_y_r    <= POS_W'(START_Y);
         dir_r      <= START_DIR;
         pend_valid <= 1'b0;
         pend_dir   <= 2'b00;
         step_r     <= 1'b0;
         blocked_r  <= 1'b0;
      end else begin
         step_r    <= 1'b0;
         blocked_r <= 1'b0;
         case (state)
            IDLE: begin
               pos_x_r    <= POS_W'(START_X);
               pos_y_r    <= POS_W'(START_Y);
               dir_r      <= START_DIR;
               cnt        <= '0;
               pend_valid <= bus.dir_valid;
               if (bus.dir_valid) pend_dir <= bus.dir_req;
            end
            RUN: begin
               cnt <= tick ? '0 : cnt + CNT_W'(1);
               if (tick) begin
                  if (pend_valid && pend_try[2*POS_W]) begin
                     dir_r   <= pend_dir;
                     pos_x_r <= pend_try[2*POS_W-1:POS_W];
                     pos_y_r <= pend_try[POS_W-1:0];
                     step_r  <= 1'b1;
                  end else if (cur_try[2*POS_W]) begin
                     pos_x_r <= cur_try[2*POS_W-1:POS_W];
                     pos_y_r <= cur_try[POS_W-1:0];
                     step_r  <= 1'b1;
                  end else begin
                     blocked_r <= 1'b1;
                  end
               end
               if (bus.dir_valid) begin
                  pend_valid <= 1'b1;
                  pend_dir   <= bus.dir_req;
               end else if (tick && pend_valid && pend_try[2*POS_W]) begin
                  pend_valid <= 1'b0;
               end
            end
            default: begin
            end
         endcase
         case (bus.scene)
            2'b00:   state <= IDLE;
            2'b01:   if (state == IDLE) state <= RUN;
            default: if (state == RUN) state <= HOLD;
         endcase
      end
   end

   assign bus.pos_x      = pos_x_r;
   assign bus.pos_y      = pos_y_r;
   assign bus.cur_dir    = dir_r;
   assign bus.step_pulse = step_r;
   assign bus.blocked    = blocked_r;

endmodule
